i2c_tca6416a_controller: RTL and testbench

I2C_TCA6416A_CONTROLLER -- requirements
Module: i2c_tca6416a_controller

---
 rtl/i2c_tca6416a_controller_if.sv | 24 ++
 rtl/i2c_tca6416a_controller.sv | 213 +++++++++++++++++++++
 tb/tb_i2c_tca6416a_controller.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_tca6416a_controller_if.sv
// Writer-side bus of the TCA6416A controller: transfer fields, the
// start/stop handshake and the shared bit timing.
interface i2c_tca6416a_controller_if;
    logic       unit_o;
    logic [7:0] command_o;
    logic [7:0] data_0_o;
    logic [7:0] data_1_o;
    logic       start_o;
    logic       stop_i;
    logic [1:0] bit_phase_o;
    logic       bit_phase_inc_o;

    modport master (
        output unit_o, command_o, data_0_o, data_1_o, start_o,
        output bit_phase_o, bit_phase_inc_o,
        input  stop_i
    );

    modport slave (
        input  unit_o, command_o, data_0_o, data_1_o, start_o,
        input  bit_phase_o, bit_phase_inc_o,
        output stop_i
    );
endinterface

// File: rtl/i2c_tca6416a_controller.sv
// TCA6416A controller: sends the four configuration/output-init writes to
// the two expanders after reset, then arbitrates runtime output-word writes
// from two requesters onto a single shared I2C byte writer.
module i2c_tca6416a_controller #(
    parameter int          CLOCK_DIV   = 8,
    parameter logic [15:0] CONFIG_0    = 16'h0000,
    parameter logic [15:0] CONFIG_1    = 16'h0000,
    parameter logic [15:0] OUTPUT_INIT = 16'hFFFF,
    parameter int          TIMEOUT     = 255
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        out0_req_i,
    input  logic [15:0] out0_data_i,
    output logic        out0_ack_o,
    input  logic        out1_req_i,
    input  logic [15:0] out1_data_i,
    output logic        out1_ack_o,
    output logic        init_done_o,
    output logic        busy_o,
    output logic        error_o,
    i2c_tca6416a_controller_if.master bus
);

    localparam int PRESC_W = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
    localparam int TOUT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLOCK_DIV - 1);
    localparam logic [TOUT_W-1:0]  TOUT_LAST  = TOUT_W'(TIMEOUT - 1);

    localparam logic [7:0] CMD_OUTPUT = 8'h02;
    localparam logic [7:0] CMD_CONFIG = 8'h06;

    typedef enum logic [1:0] {
        S_INIT,
        S_ISSUE,
        S_WAIT,
        S_IDLE
    } state_t;

    state_t              state_q;
    logic [1:0]          step_q;
    logic [PRESC_W-1:0]  presc_q;
    logic [1:0]          phase_q;
    logic [TOUT_W-1:0]   tout_q;
    logic                unit_q;
    logic [7:0]          cmd_q;
    logic [15:0]         word_q;
    logic                start_q;
    logic                ack0_q;
    logic                ack1_q;
    logic                init_done_q;
    logic                error_q;
    logic                rr_q;
    logic                pend0_q;
    logic                pend1_q;
    logic [15:0]         pdata0_q;
    logic [15:0]         pdata1_q;

    logic                phase_inc;
    logic                accept;
    logic                timed_out;
    logic                serve_unit1;

    // Init sequence table: {unit, command, word} for each of the four steps.
    function automatic logic [24:0] init_xfer(input logic [1:0] step);
        logic [24:0] x;
        case (step)
            2'd0:    x = {1'b0, CMD_CONFIG, CONFIG_0};
            2'd1:    x = {1'b1, CMD_CONFIG, CONFIG_1};
            2'd2:    x = {1'b0, CMD_OUTPUT, OUTPUT_INIT};
            default: x = {1'b1, CMD_OUTPUT, OUTPUT_INIT};
        endcase
        return x;
    endfunction

    assign phase_inc = (presc_q == PRESC_LAST);

    // Decode acceptance, timeout expiry and the round-robin winner.
    always_comb begin
        accept      = 1'b0;
        timed_out   = 1'b0;
        serve_unit1 = 1'b0;
        accept      = (state_q == S_ISSUE) && phase_inc && (phase_q == 2'd3);
        timed_out   = (state_q == S_WAIT) && !bus.stop_i && phase_inc && (tout_q == TOUT_LAST);
        serve_unit1 = pend1_q && (!pend0_q || rr_q);
    end

    // Free-running bit-phase prescaler; the phase advances on the clock after each inc pulse.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            presc_q <= '0;
            phase_q <= 2'd0;
        end else if (phase_inc) begin
            presc_q <= '0;
            phase_q <= phase_q + 2'd1;
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
        end
    end

    // Transfer sequencer: init steps, runtime arbitration, timeout and pending capture.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= S_INIT;
            step_q      <= 2'd0;
            tout_q      <= '0;
            unit_q      <= 1'b0;
            cmd_q       <= 8'h00;
            word_q      <= 16'h0000;
            start_q     <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            init_done_q <= 1'b0;
            error_q     <= 1'b0;
            rr_q        <= 1'b0;
            pend0_q     <= 1'b0;
            pend1_q     <= 1'b0;
            pdata0_q    <= 16'h0000;
            pdata1_q    <= 16'h0000;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;

            case (state_q)
                S_INIT: begin
                    {unit_q, cmd_q, word_q} <= init_xfer(step_q);
                    start_q <= 1'b1;
                    state_q <= S_ISSUE;
                end

                S_ISSUE: begin
                    if (accept) begin
                        start_q <= 1'b0;
                        tout_q  <= '0;
                        state_q <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (phase_inc && !bus.stop_i) begin
                        tout_q <= tout_q + TOUT_W'(1);
                    end
                    if (bus.stop_i || timed_out) begin
                        if (timed_out) begin
                            error_q <= 1'b1;
                        end
                        if (!init_done_q) begin
                            if (step_q == 2'd3) begin
                                init_done_q <= 1'b1;
                                state_q     <= S_IDLE;
                            end else begin
                                step_q  <= step_q + 2'd1;
                                {unit_q, cmd_q, word_q} <= init_xfer(step_q + 2'd1);
                                start_q <= 1'b1;
                                state_q <= S_ISSUE;
                            end
                        end else begin
                            state_q <= S_IDLE;
                            if (bus.stop_i) begin
                                if (unit_q) begin
                                    ack1_q <= 1'b1;
                                end else begin
                                    ack0_q <= 1'b1;
                                end
                            end
                        end
                    end
                end

                default: begin
                    if (init_done_q && (pend0_q || pend1_q)) begin
                        unit_q  <= serve_unit1;
                        cmd_q   <= CMD_OUTPUT;
                        word_q  <= serve_unit1 ? pdata1_q : pdata0_q;
                        start_q <= 1'b1;
                        rr_q    <= !serve_unit1;
                        state_q <= S_ISSUE;
                        if (serve_unit1) begin
                            pend1_q <= 1'b0;
                        end else begin
                            pend0_q <= 1'b0;
                        end
                    end
                end
            endcase

            // A request on the same clock as its unit entering ISSUE must win over the clear.
            if (out0_req_i) begin
                pend0_q  <= 1'b1;
                pdata0_q <= out0_data_i;
            end
            if (out1_req_i) begin
                pend1_q  <= 1'b1;
                pdata1_q <= out1_data_i;
            end
        end
    end

    assign bus.unit_o          = unit_q;
    assign bus.command_o       = cmd_q;
    assign bus.data_0_o        = word_q[7:0];
    assign bus.data_1_o        = word_q[15:8];
    assign bus.start_o         = start_q;
    assign bus.bit_phase_o     = phase_q;
    assign bus.bit_phase_inc_o = phase_inc;

    assign out0_ack_o  = ack0_q;
    assign out1_ack_o  = ack1_q;
    assign init_done_o = init_done_q;
    assign error_o     = error_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_tca6416a_controller.sv
// Bench for the TCA6416A controller with a behavioural writer in the loop and
// a scoreboard of expected transfers.
module tb_i2c_tca6416a_controller;

    logic        clock_i;
    logic        reset_n_i;
    logic        out0_req_i;
    logic [15:0] out0_data_i;
    logic        out0_ack_o;
    logic        out1_req_i;
    logic [15:0] out1_data_i;
    logic        out1_ack_o;
    logic        init_done_o;
    logic        busy_o;
    logic        error_o;

    i2c_tca6416a_controller_if bus();

    i2c_tca6416a_controller #(
        .CLOCK_DIV   (4),
        .CONFIG_0    (16'h00F0),
        .CONFIG_1    (16'hC30F),
        .OUTPUT_INIT (16'hFFFF),
        .TIMEOUT     (255)
    ) dut (
        .clock_i     (clock_i),
        .reset_n_i   (reset_n_i),
        .out0_req_i  (out0_req_i),
        .out0_data_i (out0_data_i),
        .out0_ack_o  (out0_ack_o),
        .out1_req_i  (out1_req_i),
        .out1_data_i (out1_data_i),
        .out1_ack_o  (out1_ack_o),
        .init_done_o (init_done_o),
        .busy_o      (busy_o),
        .error_o     (error_o),
        .bus         (bus)
    );

    typedef struct {
        logic        unit;
        logic [15:0] word;
        logic [7:0]  exp_d0;
        logic [7:0]  exp_d1;
        int          exp_ack0;
        int          exp_ack1;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [24:0] sb_q[$];
    int          ack_log[$];
    int          ack0_cnt = 0;
    int          ack1_cnt = 0;
    int          accept_cnt = 0;
    logic        stub_writer = 1'b0;

    // 100 MHz system clock.
    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input logic unit, input logic [7:0] cmd, input logic [7:0] d0, input logic [7:0] d1);
        sb_q.push_back({unit, cmd, d0, d1});
    endtask

    task automatic pushInit();
        pushExpected(1'b0, 8'h06, 8'hF0, 8'h00);
        pushExpected(1'b1, 8'h06, 8'h0F, 8'hC3);
        pushExpected(1'b0, 8'h02, 8'hFF, 8'hFF);
        pushExpected(1'b1, 8'h02, 8'hFF, 8'hFF);
    endtask

    // Pulses one request for a clock; optionally records the transfer it should produce.
    task automatic applyStimulus(input logic unit, input logic [15:0] word, input logic expect_xfer,
                                 input logic [7:0] e0, input logic [7:0] e1);
        if (expect_xfer) pushExpected(unit, 8'h02, e0, e1);
        if (unit) begin
            out1_req_i  = 1'b1;
            out1_data_i = word;
        end else begin
            out0_req_i  = 1'b1;
            out0_data_i = word;
        end
        @(negedge clock_i);
        out0_req_i = 1'b0;
        out1_req_i = 1'b0;
    endtask

    function automatic logic [32:0] resetVector();
        return {bus.start_o, bus.bit_phase_inc_o, out0_ack_o, out1_ack_o, error_o, init_done_o,
                bus.unit_o, bus.command_o, bus.data_0_o, bus.data_1_o, bus.bit_phase_o};
    endfunction

    // Writer model: checks each new transfer against the scoreboard and answers with stop_i.
    initial begin : writer_model
        logic        prev_start;
        int          countdown;
        logic [24:0] got;
        logic [24:0] exp;
        prev_start = 1'b0;
        countdown  = 0;
        bus.stop_i = 1'b0;
        forever begin
            @(negedge clock_i);
            bus.stop_i = 1'b0;
            if (!reset_n_i) begin
                prev_start = 1'b0;
                countdown  = 0;
            end else begin
                if (bus.start_o && !prev_start) begin
                    got = {bus.unit_o, bus.command_o, bus.data_0_o, bus.data_1_o};
                    checkOutput("xfer_expected", 64'(sb_q.size() != 0), 64'd1);
                    if (sb_q.size() != 0) begin
                        exp = sb_q.pop_front();
                        checkOutput("xfer_fields", 64'(got), 64'(exp));
                    end
                end
                if (prev_start && !bus.start_o) begin
                    accept_cnt++;
                    if (!stub_writer) countdown = 6;
                end else if (countdown > 0) begin
                    countdown--;
                    if (countdown == 0) bus.stop_i = 1'b1;
                end
                prev_start = bus.start_o;
            end
        end
    end

    // Ack monitor: counts pulses per unit and logs their order.
    initial begin : ack_monitor
        forever begin
            @(negedge clock_i);
            if (out0_ack_o) begin
                ack0_cnt++;
                ack_log.push_back(0);
            end
            if (out1_ack_o) begin
                ack1_cnt++;
                ack_log.push_back(1);
            end
        end
    end

    initial begin : main
        vec_t       vecs[4];
        int         n;
        int         a0;
        int         a1;
        int         acc;
        logic [1:0] p;
        logic [3:0] inc_seen;
        logic [7:0] ph_seen;
        logic [7:0] ph_exp;

        vecs[0] = '{1'b0, 16'hA55A, 8'h5A, 8'hA5, 1, 0};
        vecs[1] = '{1'b1, 16'h1234, 8'h34, 8'h12, 0, 1};
        vecs[2] = '{1'b1, 16'h00FF, 8'hFF, 8'h00, 0, 1};
        vecs[3] = '{1'b0, 16'h8001, 8'h01, 8'h80, 1, 0};

        reset_n_i   = 1'b0;
        out0_req_i  = 1'b0;
        out0_data_i = 16'h0000;
        out1_req_i  = 1'b0;
        out1_data_i = 16'h0000;

        repeat (3) @(negedge clock_i);
        checkOutput("reset_outputs", 64'(resetVector()), 64'd0);

        pushInit();
        reset_n_i = 1'b1;
        checkOutput("busy_in_init", 64'(busy_o), 64'd1);

        // Prescaler: first inc three clocks after release with phase 0, then every 4 clocks.
        n = 0;
        while (!bus.bit_phase_inc_o && n < 8) begin
            @(negedge clock_i);
            n++;
        end
        checkOutput("first_inc_delay", 64'(n), 64'd3);
        checkOutput("first_inc_phase", 64'(bus.bit_phase_o), 64'd0);
        p = 2'd0;
        for (int k = 0; k < 4; k++) begin
            p = p + 2'd1;
            for (int j = 0; j < 4; j++) begin
                @(negedge clock_i);
                inc_seen[j]       = bus.bit_phase_inc_o;
                ph_seen[j*2 +: 2] = bus.bit_phase_o;
            end
            ph_exp = {p, p, p, p};
            checkOutput("prescaler_period", {52'd0, inc_seen, ph_seen}, {52'd0, 4'b1000, ph_exp});
        end

        n = 0;
        while (!init_done_o && n < 600) begin
            @(negedge clock_i);
            n++;
        end
        checkOutput("init_done", 64'(init_done_o), 64'd1);
        checkOutput("idle_after_init", 64'({busy_o, error_o}), 64'd0);
        checkOutput("init_xfers_consumed", 64'(sb_q.size()), 64'd0);

        // Table-driven single writes.
        for (int i = 0; i < 4; i++) begin
            a0 = ack0_cnt;
            a1 = ack1_cnt;
            applyStimulus(vecs[i].unit, vecs[i].word, 1'b1, vecs[i].exp_d0, vecs[i].exp_d1);
            n = 0;
            while (!bus.start_o && n < 8) begin
                @(negedge clock_i);
                n++;
            end
            checkOutput("start_latency", 64'(n), 64'd1);
            n = 0;
            while ((ack0_cnt + ack1_cnt) == (a0 + a1) && n < 200) begin
                @(negedge clock_i);
                n++;
            end
            repeat (3) @(negedge clock_i);
            checkOutput("ack_counts", {32'(ack0_cnt - a0), 32'(ack1_cnt - a1)},
                        {32'(vecs[i].exp_ack0), 32'(vecs[i].exp_ack1)});
            checkOutput("busy_after_write", 64'(busy_o), 64'd0);
        end

        // Simultaneous requests after a unit 0 write: unit 1 goes first.
        pushExpected(1'b1, 8'h02, 8'h22, 8'h11);
        pushExpected(1'b0, 8'h02, 8'h44, 8'h33);
        n = ack_log.size();
        out0_req_i  = 1'b1;
        out0_data_i = 16'h3344;
        out1_req_i  = 1'b1;
        out1_data_i = 16'h1122;
        @(negedge clock_i);
        out0_req_i = 1'b0;
        out1_req_i = 1'b0;
        a0 = 0;
        while (ack_log.size() < n + 2 && a0 < 400) begin
            @(negedge clock_i);
            a0++;
        end
        checkOutput("rr_ack_count", 64'(ack_log.size() - n), 64'd2);
        if (ack_log.size() >= n + 2) begin
            checkOutput("rr_ack_order", {32'(ack_log[n]), 32'(ack_log[n+1])}, {32'd1, 32'd0});
        end

        // Writer never answers: timeout sets error, no ack, FSM back to idle.
        stub_writer = 1'b1;
        a0 = ack0_cnt;
        a1 = ack1_cnt;
        applyStimulus(1'b1, 16'hBEEF, 1'b1, 8'hEF, 8'hBE);
        n = 0;
        while (!error_o && n < 1500) begin
            @(negedge clock_i);
            n++;
        end
        checkOutput("timeout_error", 64'(error_o), 64'd1);
        repeat (3) @(negedge clock_i);
        checkOutput("timeout_idle", 64'(busy_o), 64'd0);
        checkOutput("timeout_no_ack", 64'((ack0_cnt - a0) + (ack1_cnt - a1)), 64'd0);
        stub_writer = 1'b0;

        // Reset during WAIT clears outputs at once; init restarts from step 0.
        acc = accept_cnt;
        applyStimulus(1'b0, 16'h1357, 1'b1, 8'h57, 8'h13);
        n = 0;
        while (accept_cnt == acc && n < 100) begin
            @(negedge clock_i);
            n++;
        end
        checkOutput("wait_reached", 64'(accept_cnt - acc), 64'd1);
        @(posedge clock_i);
        #1;
        reset_n_i = 1'b0;
        #1;
        checkOutput("async_reset_clear", 64'(resetVector()), 64'd0);
        repeat (3) @(negedge clock_i);
        a0 = ack0_cnt;
        pushInit();
        reset_n_i = 1'b1;
        repeat (3) @(negedge clock_i);
        applyStimulus(1'b0, 16'h1111, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clock_i);
        applyStimulus(1'b0, 16'h2222, 1'b1, 8'h22, 8'h22);
        n = 0;
        while (!init_done_o && n < 600) begin
            @(negedge clock_i);
            n++;
        end
        checkOutput("reinit_done", 64'(init_done_o), 64'd1);
        n = 0;
        while (ack0_cnt == a0 && n < 200) begin
            @(negedge clock_i);
            n++;
        end
        repeat (3) @(negedge clock_i);
        checkOutput("latest_wins_ack", 64'(ack0_cnt - a0), 64'd1);
        checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        checkOutput("error_cleared", 64'(error_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
